// File: rtl/zap_mac_iterative_if.sv
// rtl/zap_mac_iterative_if.sv - operand/result bundle between the pipeline and the iterative MAC
interface zap_mac_iterative_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic             i_signed;
    logic             i_accumulate;
    logic [WIDTH-1:0] i_rm;
    logic [WIDTH-1:0] i_rs;
    logic [WIDTH-1:0] i_rn;
    logic [WIDTH-1:0] i_rh;
    logic [WIDTH-1:0] o_rd_lo;
    logic [WIDTH-1:0] o_rd_hi;
    logic             o_done;
    logic             o_busy;
    logic             o_nozero;

    modport master (
        output i_start, i_signed, i_accumulate, i_rm, i_rs, i_rn, i_rh,
        input  o_rd_lo, o_rd_hi, o_done, o_busy, o_nozero
    );

    modport slave (
        input  i_start, i_signed, i_accumulate, i_rm, i_rs, i_rn, i_rh,
        output o_rd_lo, o_rd_hi, o_done, o_busy, o_nozero
    );
endinterface

// File: rtl/zap_mac_iterative.sv
// rtl/zap_mac_iterative.sv - multi-cycle signed/unsigned 2W-bit multiply-accumulate, RADIX_BITS per cycle
module zap_mac_iterative #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_clear,
    input  logic               i_data_stall,
    zap_mac_iterative_if.slave bus
);
    localparam int N  = WIDTH / RADIX_BITS;
    localparam int CW = $clog2(N + 1);
    localparam int W2 = 2 * WIDTH;

    generate
        if (WIDTH % RADIX_BITS != 0) begin : g_bad_radix
            $error("RADIX_BITS must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [W2-1:0]    prod_q, prod_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rd_lo_q, rd_lo_d;
    logic [WIDTH-1:0] rd_hi_q, rd_hi_d;
    logic             done_q, done_d;
    logic             nozero_q, nozero_d;

    logic [W2-1:0]    partial;
    logic [W2-1:0]    res;
    logic [WIDTH-1:0] rm_mag, rs_mag;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        rd_lo_d  = rd_lo_q;
        rd_hi_d  = rd_hi_q;
        done_d   = done_q;
        nozero_d = nozero_q;

        // Magnitudes stay W-bit unsigned, so the most negative operand maps to 2^(W-1) exactly.
        rm_mag  = (bus.i_signed && bus.i_rm[WIDTH-1]) ? -bus.i_rm : bus.i_rm;
        rs_mag  = (bus.i_signed && bus.i_rs[WIDTH-1]) ? -bus.i_rs : bus.i_rs;
        partial = (W2'(mcand_q) * W2'(mplier_q[RADIX_BITS-1:0])) << (int'(cnt_q) * RADIX_BITS);
        res     = (neg_q ? -prod_q : prod_q) + acc_q;

        if (i_clear) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else if (!i_data_stall) begin
            case (state_q)
                S_IDLE: begin
                    done_d = 1'b0;
                    if (bus.i_start) begin
                        mcand_d  = rm_mag;
                        mplier_d = rs_mag;
                        neg_d    = bus.i_signed & (bus.i_rm[WIDTH-1] ^ bus.i_rs[WIDTH-1]);
                        acc_d    = bus.i_accumulate ? {bus.i_rh, bus.i_rn} : '0;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end
                end
                S_MUL: begin
                    prod_d   = prod_q + partial;
                    mplier_d = mplier_q >> RADIX_BITS;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    rd_lo_d  = res[WIDTH-1:0];
                    rd_hi_d  = res[W2-1:WIDTH];
                    nozero_d = |res;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
                default: begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            rd_lo_q  <= '0;
            rd_hi_q  <= '0;
            done_q   <= 1'b0;
            nozero_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            rd_lo_q  <= rd_lo_d;
            rd_hi_q  <= rd_hi_d;
            done_q   <= done_d;
            nozero_q <= nozero_d;
        end
    end

    // Busy covers the request cycle itself so the issuing instruction holds in place.
    assign bus.o_busy   = (state_q == S_MUL) || (state_q == S_FIX) ||
                          ((state_q == S_IDLE) && bus.i_start);
    assign bus.o_done   = done_q;
    assign bus.o_rd_lo  = rd_lo_q;
    assign bus.o_rd_hi  = rd_hi_q;
    assign bus.o_nozero = nozero_q;
endmodule

// File: tb/tb_zap_mac_iterative.sv
// tb/tb_zap_mac_iterative.sv - self-checking bench for zap_mac_iterative
module tb_zap_mac_iterative;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic i_clear;
    logic i_data_stall;
    logic sweep_go = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    zap_mac_iterative_if #(.WIDTH(32)) bus ();

    zap_mac_iterative #(.WIDTH(32), .RADIX_BITS(2)) u_dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_clear      (i_clear),
        .i_data_stall (i_data_stall),
        .bus          (bus)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Full-precision reference: sign-extend to 64 bits, multiply, add, truncate to 2w bits.
    function automatic logic [63:0] mac_model(input int w, input logic [31:0] rm, input logic [31:0] rs,
                                              input logic [31:0] rn, input logic [31:0] rh,
                                              input bit sg, input bit ac);
        logic [63:0] a, b, acc, lowmask, mask;
        lowmask = (64'd1 << w) - 64'd1;
        mask    = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        a = {32'b0, rm} & lowmask;
        b = {32'b0, rs} & lowmask;
        if (sg && rm[w-1]) a = a | ~lowmask;
        if (sg && rs[w-1]) b = b | ~lowmask;
        acc = ac ? ((({32'b0, rh} & lowmask) << w) | ({32'b0, rn} & lowmask)) : 64'd0;
        return (a * b + acc) & mask;
    endfunction

    // Timeline model: t=0 idle, 1..N multiply, N+1 fixup, N+2 result-valid cycle.
    int          t = 0;
    logic        mdl_valid = 1'b0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_res = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            t         <= 0;
            m_res     <= '0;
            mdl_valid <= 1'b1;
        end else if (i_clear) begin
            t <= 0;
        end else if (!i_data_stall) begin
            if (t == 0) begin
                if (bus.i_start) begin
                    t      <= 1;
                    m_pend <= mac_model(32, bus.i_rm, bus.i_rs, bus.i_rn, bus.i_rh,
                                        bus.i_signed, bus.i_accumulate);
                end
            end else if (t == N + 1) begin
                m_res <= m_pend;
                t     <= N + 2;
            end else if (t == N + 2) begin
                t <= 0;
            end else begin
                t <= t + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_valid) begin
            check("busy", 64'(bus.o_busy), 64'(((t >= 1) && (t <= N + 1)) || ((t == 0) && bus.i_start)));
            check("done", 64'(bus.o_done), 64'(t == N + 2));
            check("result", {bus.o_rd_hi, bus.o_rd_lo}, m_res);
            check("nozero", 64'(bus.o_nozero), 64'(m_res != 64'd0));
        end
    end

    task automatic run_op(input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                          input logic [31:0] rh, input bit sg, input bit ac,
                          input int stall_at, input int stall_len, input int clear_at,
                          input bit hold_start, output int lat, output bit got_done);
        @(posedge clk); #1;
        bus.i_rm = rm; bus.i_rs = rs; bus.i_rn = rn; bus.i_rh = rh;
        bus.i_signed = sg; bus.i_accumulate = ac; bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        lat = 0;
        got_done = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            i_data_stall = (stall_len > 0) && (e >= stall_at) && (e < stall_at + stall_len);
            i_clear      = (e == clear_at);
            @(posedge clk); #1;
            i_clear      = 1'b0;
            i_data_stall = 1'b0;
            if (bus.o_done && !got_done) begin
                got_done = 1'b1;
                lat = e;
                if (hold_start) begin
                    bus.i_start = 1'b1;
                    @(posedge clk); #1;
                    bus.i_start = 1'b0;
                end
                if (clear_at == 0) break;
            end
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int R = 1 << g;
        bit fin = 1'b0;
        zap_mac_iterative_if #(.WIDTH(16)) sb ();
        zap_mac_iterative #(.WIDTH(16), .RADIX_BITS(R)) u_sweep (
            .i_clk        (clk),
            .i_reset_n    (rst_n),
            .i_clear      (1'b0),
            .i_data_stall (1'b0),
            .bus          (sb)
        );
        initial begin
            logic [15:0] rm, rs, rn, rh;
            bit          sg, ac;
            int          lat;
            sb.i_start = 1'b0; sb.i_signed = 1'b0; sb.i_accumulate = 1'b0;
            sb.i_rm = '0; sb.i_rs = '0; sb.i_rn = '0; sb.i_rh = '0;
            wait (sweep_go);
            for (int k = 0; k < 8; k++) begin
                rm = (k == 0) ? 16'h8000 : 16'($urandom);
                rs = (k == 0) ? 16'h8000 : 16'($urandom);
                rn = 16'($urandom);
                rh = 16'($urandom);
                sg = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                ac = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                sb.i_rm = rm; sb.i_rs = rs; sb.i_rn = rn; sb.i_rh = rh;
                sb.i_signed = sg; sb.i_accumulate = ac; sb.i_start = 1'b1;
                @(posedge clk); #1;
                sb.i_start = 1'b0;
                lat = 0;
                for (int e = 1; e <= 40; e++) begin
                    @(posedge clk); #1;
                    if (sb.o_done) begin
                        lat = e;
                        break;
                    end
                end
                check($sformatf("sweep_r%0d_lat", R), 64'(lat), 64'(16 / R + 1));
                check($sformatf("sweep_r%0d_res", R), {32'b0, sb.o_rd_hi, sb.o_rd_lo},
                      mac_model(16, {16'b0, rm}, {16'b0, rs}, {16'b0, rn}, {16'b0, rh}, sg, ac));
                check($sformatf("sweep_r%0d_nz", R), 64'(sb.o_nozero),
                      64'(mac_model(16, {16'b0, rm}, {16'b0, rs}, {16'b0, rn}, {16'b0, rh}, sg, ac) != 0));
            end
            fin = 1'b1;
        end
    end

    initial begin
        int lat;
        bit got;
        rst_n = 1'b0; i_clear = 1'b0; i_data_stall = 1'b0;
        bus.i_start = 1'b0; bus.i_signed = 1'b0; bus.i_accumulate = 1'b0;
        bus.i_rm = '0; bus.i_rs = '0; bus.i_rn = '0; bus.i_rh = '0;

        check("pin_uns_max", mac_model(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0), 64'hFFFF_FFFE_0000_0001);
        check("pin_sgn_min", mac_model(32, 32'h8000_0000, 32'hFFFF_FFFF, 5, 0, 1'b1, 1'b1), 64'h0000_0000_8000_0005);
        check("pin_w16_sgn", mac_model(16, 32'h8000, 32'h8000, 0, 0, 1'b1, 1'b0), 64'h4000_0000);
        check("pin_w16_uns", mac_model(16, 32'hFFFF, 32'hFFFF, 0, 0, 1'b0, 1'b0), 64'hFFFE_0001);

        repeat (2) @(posedge clk);
        #1;
        check("rst_lo", 64'(bus.o_rd_lo), 64'd0);
        check("rst_hi", 64'(bus.o_rd_hi), 64'd0);
        check("rst_done", 64'(bus.o_done), 64'd0);
        check("rst_nozero", 64'(bus.o_nozero), 64'd0);
        check("rst_busy", 64'(bus.o_busy), 64'd0);
        rst_n = 1'b1;

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0, lat, got);
        check("t2_lat", 64'(lat), 64'd17);
        check("t2_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'hFFFF_FFFE_0000_0001);
        check("t2_nz", 64'(bus.o_nozero), 64'd1);

        run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd0, 1'b1, 1'b1, 0, 0, 0, 1'b0, lat, got);
        check("t3_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'h0000_0000_8000_0005);

        run_op(32'hFFFF_FFFE, 32'd3, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0, lat, got);
        check("t4_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        run_op(32'hFFFF_FFFE, 32'd0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b1, lat, got);
        check("t4_zero_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'd0);
        check("t4_zero_nz", 64'(bus.o_nozero), 64'd0);

        run_op(32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 0, 0, 0, 1'b0, lat, got);
        check("carry_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'h0000_0001_0000_0000);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 5, 4, 0, 1'b0, lat, got);
        check("t5_lat", 64'(lat), 64'd21);
        check("t5_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'hFFFF_FFFE_0000_0001);

        run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd0, 1'b1, 1'b1, 0, 0, 7, 1'b0, lat, got);
        check("t6_no_done", 64'(got), 64'd0);
        check("t6_held", {bus.o_rd_hi, bus.o_rd_lo}, 64'hFFFF_FFFE_0000_0001);

        run_op(32'hFFFF_FFFE, 32'd3, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0, lat, got);
        check("t6_restart_lat", 64'(lat), 64'd17);
        check("t6_restart_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        sweep_go = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            if (g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin) break;
            @(posedge clk);
        end
        check("sweep_complete",
              64'({g_sweep[3].fin, g_sweep[2].fin, g_sweep[1].fin, g_sweep[0].fin}), 64'hF);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
